// File: rtl/lime_io_ports.sv
// lime_io_ports: memory-mapped I/O port block for the Lime processor.
// Each channel has an input FIFO, an output FIFO and sticky error flags.
// The channel DATA and STATUS registers sit in a small window at BASE_ADDR.
module lime_io_ports #(
  parameter int               WIDTH     = 16,
  parameter int               N_CH      = 2,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] BASE_ADDR = 16'hFF00
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        bus_addr,
  input  logic [WIDTH-1:0]        bus_wdata,
  input  logic                    bus_we,
  input  logic                    bus_re,
  output logic                    bus_hit,
  output logic [WIDTH-1:0]        bus_rdata,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [N_CH*WIDTH-1:0]   out_data,
  output logic [N_CH-1:0]         out_valid,
  input  logic [N_CH-1:0]         out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0]            offset;
  logic [2:0]                  chSel;
  logic                        isStatus;
  logic                        busReadOnly;
  logic [N_CH-1:0][WIDTH-1:0]  chData;
  logic [N_CH-1:0][WIDTH-1:0]  chStatus;

  // The window is decoded from the offset; with N_CH <= 8 and a hit,
  // the offset fits in 4 bits: [3:1] picks the channel, [0] picks STATUS.
  assign offset      = bus_addr - BASE_ADDR;
  assign bus_hit     = (offset < WIDTH'(2 * N_CH));
  assign chSel       = offset[3:1];
  assign isStatus    = offset[0];
  // A simultaneous store wins over the load's side effects.
  assign busReadOnly = bus_re && !bus_we;

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : gCh
      logic [WIDTH-1:0] inMem  [DEPTH];
      logic [WIDTH-1:0] outMem [DEPTH];
      logic [PW-1:0]    inWr_q, inWr_d, inRd_q, inRd_d;
      logic [PW-1:0]    outWr_q, outWr_d, outRd_q, outRd_d;
      logic [CW-1:0]    inCnt_q, inCnt_d, outCnt_q, outCnt_d;
      logic             underflow_q, underflow_d, overflow_q, overflow_d;
      logic             sel, dataSel, statSel;
      logic             inEmpty, inFull, outEmpty, outFull;
      logic             inPush, inPop, outPush, outPop;
      logic [CW-1:0]    outFree;
      logic [WIDTH-1:0] statusWord;

      assign sel      = bus_hit && (chSel == 3'(c));
      assign dataSel  = sel && !isStatus;
      assign statSel  = sel && isStatus;

      assign inEmpty  = (inCnt_q == '0);
      assign inFull   = (inCnt_q == CW'(DEPTH));
      assign outEmpty = (outCnt_q == '0);
      assign outFull  = (outCnt_q == CW'(DEPTH));
      assign outFree  = CW'(DEPTH) - outCnt_q;

      // Full/empty come from pre-edge state, so a same-cycle pop never
      // opens room for a push and a same-cycle push never feeds a pop.
      assign inPush   = in_valid[c] && !inFull;
      assign inPop    = dataSel && busReadOnly && !inEmpty;
      assign outPush  = dataSel && bus_we && !outFull;
      assign outPop   = out_ready[c] && !outEmpty;

      assign in_ready[c]  = !inFull;
      assign out_valid[c] = !outEmpty;
      assign out_data[c*WIDTH +: WIDTH] = outEmpty ? '0 : outMem[outRd_q];
      assign chData[c]    = inEmpty ? '0 : inMem[inRd_q];
      assign chStatus[c]  = statusWord;

      // Next-state for pointers, counts and sticky error flags.
      always_comb begin
        inWr_d      = inPush  ? inWr_q  + 1'b1 : inWr_q;
        inRd_d      = inPop   ? inRd_q  + 1'b1 : inRd_q;
        outWr_d     = outPush ? outWr_q + 1'b1 : outWr_q;
        outRd_d     = outPop  ? outRd_q + 1'b1 : outRd_q;
        inCnt_d     = inCnt_q  + CW'(inPush)  - CW'(inPop);
        outCnt_d    = outCnt_q + CW'(outPush) - CW'(outPop);
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        if (statSel && bus_we && bus_wdata[2]) underflow_d = 1'b0;
        if (statSel && bus_we && bus_wdata[3]) overflow_d  = 1'b0;
        if (dataSel && busReadOnly && inEmpty) underflow_d = 1'b1;
        if (dataSel && bus_we && outFull)      overflow_d  = 1'b1;
      end

      // Control state register; reset discards all buffered data.
      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          inWr_q      <= '0;
          inRd_q      <= '0;
          outWr_q     <= '0;
          outRd_q     <= '0;
          inCnt_q     <= '0;
          outCnt_q    <= '0;
          underflow_q <= 1'b0;
          overflow_q  <= 1'b0;
        end else begin
          inWr_q      <= inWr_d;
          inRd_q      <= inRd_d;
          outWr_q     <= outWr_d;
          outRd_q     <= outRd_d;
          inCnt_q     <= inCnt_d;
          outCnt_q    <= outCnt_d;
          underflow_q <= underflow_d;
          overflow_q  <= overflow_d;
        end
      end

      // FIFO storage is left unreset; the counts decide what is visible.
      always_ff @(posedge CLK) begin
        if (inPush)  inMem[inWr_q]   <= in_data[c*WIDTH +: WIDTH];
        if (outPush) outMem[outWr_q] <= bus_wdata;
      end

      // STATUS register layout; unused upper bits stay zero.
      always_comb begin
        statusWord        = '0;
        statusWord[0]     = !inEmpty;
        statusWord[1]     = !outFull;
        statusWord[2]     = underflow_q;
        statusWord[3]     = overflow_q;
        statusWord[7:4]   = 4'(inCnt_q);
        statusWord[11:8]  = 4'(outFree);
      end
    end
  endgenerate

  // Read data is driven only for a load that hits the window.
  always_comb begin
    bus_rdata = '0;
    if (bus_hit && bus_re) begin
      for (int i = 0; i < N_CH; i++) begin
        if (chSel == 3'(i)) bus_rdata = isStatus ? chStatus[i] : chData[i];
      end
    end
  end

endmodule
